// File: rtl/pulse_stretch_arbiter.sv
// pulse_stretch_arbiter
//
// Purpose: latches single-cycle event pulses from NREQ requesters and serves
// them one at a time, round-robin, on a shared output pulse that is stretched
// to exactly WIDTH cycles and followed by GAP mandatory low cycles.
// Events arriving for a requester that is already pending are coalesced and
// counted as drops.
//
// Ports:
//   clk         - sole clock, all state changes on its rising edge
//   reset       - synchronous, active-high
//   req         - [NREQ] per-requester single-cycle event pulses
//   stretch_out - shared stretched pulse, high WIDTH cycles per grant
//   grant_id    - owner of the current or most recent stretched pulse
//   busy        - high whenever the FSM is not IDLE
//   pending     - [NREQ] latched, not-yet-served events
//   drop_cnt    - [CNTW] count of edges on which at least one event coalesced
//   state_dbg   - current FSM state (0 IDLE, 1 STRETCH, 2 GAP) for observation
//
// Configuration macro: PULSE_ARB_DROP_CNT_EN
//   defined   - drop_cnt is a saturating counter
//   undefined - drop_cnt is tied to 0 and no counter is built
module pulse_stretch_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 6,
    parameter int GAP   = 2,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    output logic                     stretch_out,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic [NREQ-1:0]          pending,
    output logic [CNTW-1:0]          drop_cnt,
    output logic [1:0]               state_dbg
);

    localparam int IDW  = $clog2(NREQ);
    localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] grant_mask;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  idx;
    logic            winner_vld;

    // Round-robin search: first pending requester starting at last_grant+1,
    // wrapping from NREQ-1 back to 0. last_grant itself is checked last.
    always_comb begin
        winner     = '0;
        winner_vld = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_q) + k) % NREQ);
            if (!winner_vld && pend_q[idx]) begin
                winner     = idx;
                winner_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        last_d     = last_q;
        grant_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (winner_vld) begin
                    state_d            = ST_STRETCH;
                    cnt_d              = '0;
                    grant_d            = winner;
                    last_d             = winner;
                    grant_mask[winner] = 1'b1;
                end
            end
            ST_STRETCH: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // A new event on the granting edge survives the clear.
        pend_d = (pend_q & ~grant_mask) | req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= IDW'(NREQ - 1);
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end

`ifdef PULSE_ARB_DROP_CNT_EN
    logic [CNTW-1:0] drop_q, drop_d;
    logic            drop_ev;

    // One increment per edge no matter how many requesters coalesce on it.
    always_comb begin
        drop_ev = |(req & pend_q & ~grant_mask);
        drop_d  = drop_q;
        if (drop_ev && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    // All outputs decode registers only; req has no path to stretch_out.
    assign stretch_out = (state_q == ST_STRETCH);
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_q;
    assign pending     = pend_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pulse_stretch_arbiter.sv
// Testbench for pulse_stretch_arbiter (NREQ=4, WIDTH=6, GAP=2, CNTW=8).
// Directed scenarios check fixed timing values; the random scenario checks
// every cycle against a timeline model of the arbiter.
module tb_pulse_stretch_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 6;
    localparam int GAP   = 2;
    localparam int CNTW  = 8;
    localparam int GW    = $clog2(NREQ);
    localparam int DMAX  = (1 << CNTW) - 1;
`ifdef PULSE_ARB_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic            stretch_out;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic [NREQ-1:0] pending;
    logic [CNTW-1:0] drop_cnt;
    logic [1:0]      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model: m_t counts cycles since the last grant (-1 when idle).
    logic [NREQ-1:0] m_pend;
    int              m_last;
    int              m_grant;
    int              m_t;
    int              m_drop;

    pulse_stretch_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .GAP  (GAP),
        .CNTW (CNTW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .stretch_out(stretch_out),
        .grant_id   (grant_id),
        .busy       (busy),
        .pending    (pending),
        .drop_cnt   (drop_cnt),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_edge(input logic [NREQ-1:0] r, input logic rst);
        int g;
        logic [NREQ-1:0] gm;
        if (rst) begin
            m_pend  = '0;
            m_last  = NREQ - 1;
            m_grant = 0;
            m_t     = -1;
            m_drop  = 0;
            return;
        end
        g  = -1;
        gm = '0;
        if (m_t < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (g < 0 && m_pend[i]) g = i;
            end
            if (g >= 0) begin
                m_t     = 0;
                m_grant = g;
                m_last  = g;
                gm[g]   = 1'b1;
            end
        end else begin
            m_t++;
            if (m_t == WIDTH + GAP) m_t = -1;
        end
        if ((r & m_pend & ~gm) != '0 && m_drop < DMAX) m_drop++;
        m_pend = (m_pend & ~gm) | r;
    endtask

    // ---------------- driver ----------------
    // Present inputs for one edge, update the model, sample 1 time unit later.
    task automatic tick(input logic [NREQ-1:0] r, input logic rst = 1'b0);
        req   = r;
        reset = rst;
        @(posedge clk);
        model_edge(r, rst);
        #1;
        req   = '0;
        reset = 1'b0;
    endtask

    task automatic do_reset();
        tick('0, 1'b1);
        tick('0, 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (stretch_out !== 1'b0) begin n_fail++; $display("FAIL reset_stretch: got %0b want 0", stretch_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++;
        if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
        n_checks++;
        if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_checks++;
        if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    // req=0100 sampled at edge k=1 (cycle 10): cycle numbering is 10+k.
    task automatic test_single_latency();
        do_reset();
        tick(4'b0100);
        n_checks++;
        if (pending !== 4'b0100 || stretch_out !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pending: got pend=%b str=%0b busy=%0b want 0100/0/0", pending, stretch_out, busy);
        end
        for (int k = 2; k <= 11; k++) begin
            logic e_str, e_busy;
            tick('0);
            e_str  = (k <= 7);
            e_busy = (k <= 9);
            n_checks++;
            if (stretch_out !== e_str || busy !== e_busy || grant_id !== 2'd2 || pending !== 4'b0000) begin
                n_fail++;
                $display("FAIL single_cycle%0d: got str=%0b busy=%0b id=%0d pend=%b want %0b/%0b/2/0000",
                         10 + k, stretch_out, busy, grant_id, pending, e_str, e_busy);
            end
        end
    endtask

    task automatic test_all_requesters();
        int exp_k[4];
        int nrise;
        logic prev;
        exp_k = '{2, 11, 20, 29};
        nrise = 0;
        do_reset();
        prev = stretch_out;
        tick(4'b1111);
        for (int k = 2; k <= 45; k++) begin
            tick('0);
            if (stretch_out && !prev) begin
                n_checks++;
                if (nrise >= 4 || k != exp_k[nrise] || grant_id !== GW'(nrise)) begin
                    n_fail++;
                    $display("FAIL all_rise%0d: got cycle %0d id %0d want cycle %0d id %0d",
                             nrise, 10 + k, grant_id, (nrise < 4) ? 10 + exp_k[nrise] : -1, nrise);
                end
                nrise++;
            end
            prev = stretch_out;
        end
        n_checks++;
        if (nrise != 4) begin n_fail++; $display("FAIL all_rise_count: got %0d want 4", nrise); end
    endtask

    task automatic test_rr_order();
        int ids[$];
        logic prev;
        do_reset();
        prev = 1'b0;
        tick(4'b0010);
        for (int k = 2; k <= 30; k++) begin
            tick((k == 3) ? 4'b1001 : 4'b0000);
            if (k == 3) begin
                n_checks++;
                if (pending !== 4'b1001) begin n_fail++; $display("FAIL rr_pending: got %b want 1001", pending); end
            end
            if (stretch_out && !prev) ids.push_back(int'(grant_id));
            prev = stretch_out;
        end
        n_checks++;
        if (ids.size() != 3 || ids[0] != 1 || ids[1] != 3 || ids[2] != 0) begin
            n_fail++;
            $display("FAIL rr_order: got %p want '{1, 3, 0}", ids);
        end
    endtask

    task automatic test_drop();
        int n1;
        logic prev;
        n1 = 0;
        do_reset();
        prev = 1'b0;
        tick(4'b0001);                 // k1
        tick(4'b0000);                 // k2 grant 0
        tick(4'b0010);                 // k3 pending[1]
        tick(4'b0000);                 // k4
        tick(4'b0010);                 // k5 coalesced
        n_checks++;
        if (pending !== 4'b0010 || drop_cnt !== (DROP_EN ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL drop_count: got pend=%b drop=%0d want 0010/%0d", pending, drop_cnt, DROP_EN ? 1 : 0);
        end
        prev = stretch_out;
        for (int k = 6; k <= 30; k++) begin
            tick('0);
            if (stretch_out && !prev && grant_id == 2'd1) n1++;
            prev = stretch_out;
        end
        n_checks++;
        if (n1 != 1) begin n_fail++; $display("FAIL drop_one_pulse: got %0d pulses want 1", n1); end
    endtask

    task automatic test_regrant_same_edge();
        int rise_k;
        logic prev;
        rise_k = -1;
        do_reset();
        tick(4'b0001);                 // k1
        tick(4'b0001);                 // k2 grant 0 with a fresh event
        n_checks++;
        if (pending !== 4'b0001 || stretch_out !== 1'b1 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL regrant_keep: got pend=%b str=%0b drop=%0d want 0001/1/0", pending, stretch_out, drop_cnt);
        end
        prev = 1'b1;
        for (int k = 3; k <= 20; k++) begin
            tick('0);
            if (stretch_out && !prev && rise_k < 0) rise_k = k;
            prev = stretch_out;
        end
        n_checks++;
        if (rise_k != 2 + WIDTH + GAP + 1 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL regrant_spacing: got rise k=%0d id=%0d want k=%0d id=0", rise_k, grant_id, 2 + WIDTH + GAP + 1);
        end
    endtask

    task automatic test_reset_mid_stretch();
        do_reset();
        tick(4'b0001);                 // k1
        tick(4'b0100);                 // k2 stretch cycle 1
        tick(4'b0100);                 // k3 stretch cycle 2, coalesced
        tick(4'b0000);                 // k4 stretch cycle 3
        n_checks++;
        if (stretch_out !== 1'b1 || drop_cnt !== (DROP_EN ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL midrst_pre: got str=%0b drop=%0d want 1/%0d", stretch_out, drop_cnt, DROP_EN ? 1 : 0);
        end
        tick(4'b0000, 1'b1);
        n_checks++;
        if (stretch_out !== 1'b0 || busy !== 1'b0 || pending !== 4'b0000 || drop_cnt !== 8'd0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_post: got str=%0b busy=%0b pend=%b drop=%0d id=%0d want 0/0/0000/0/0",
                     stretch_out, busy, pending, drop_cnt, grant_id);
        end
        tick('0);
        tick('0);
        n_checks++;
        if (stretch_out !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: got str=%0b busy=%0b want 0/0", stretch_out, busy);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        logic            rst;
        int              dense;
        logic [CNTW-1:0] e_drop;
        do_reset();
        dense = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) dense = $urandom_range(0, 1);
            for (int i = 0; i < NREQ; i++)
                r[i] = (dense != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick(r, rst);
            e_drop = DROP_EN ? CNTW'(m_drop) : '0;
            n_checks++;
            if (stretch_out !== (m_t >= 0 && m_t < WIDTH) || busy !== (m_t >= 0) ||
                grant_id !== GW'(m_grant) || pending !== m_pend || drop_cnt !== e_drop) begin
                n_fail++;
                $display("FAIL random_c%0d: got str=%0b busy=%0b id=%0d pend=%b drop=%0d want %0b/%0b/%0d/%b/%0d",
                         c, stretch_out, busy, grant_id, pending, drop_cnt,
                         (m_t >= 0 && m_t < WIDTH), (m_t >= 0), m_grant, m_pend, e_drop);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_edge('0, 1'b1);
        test_reset();
        test_single_latency();
        test_all_requesters();
        test_rr_order();
        test_drop();
        test_regrant_same_edge();
        test_reset_mid_stretch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_stretch_arbiter.md
PULSE_STRETCH_ARBITER -- requirements
Module: pulse_stretch_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of pulse requesters, at least 2.
REQ-002 Parameter WIDTH, default 6: stretched-pulse high time in clk cycles, at least 1.
REQ-003 Parameter GAP, default 2: mandatory low cycles after each stretched pulse, at least 0.
REQ-004 Parameter CNTW, default 8: drop counter width.
REQ-005 Clock and reset: one clock, clk; reset is synchronous and active-high.
- clk, input, 1: sole clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high.
REQ-006 req, input, NREQ: per-requester single-cycle event pulses.
REQ-007 stretch_out, output, 1: shared stretched pulse, high for exactly WIDTH cycles per grant.
REQ-008 grant_id, output, clog2(NREQ): index of the requester that owns the current or most recent stretch_out pulse.
REQ-009 busy, output, 1: high whenever the FSM is not in IDLE.
REQ-010 pending, output, NREQ: latched, not-yet-served events.
REQ-011 drop_cnt, output, CNTW: count of coalesced (dropped) events.

Function
REQ-012 pending[i] SHALL set on the edge where req[i]=1.
REQ-013 pending[i] SHALL clear on the edge where requester i is granted.
REQ-014 If req[i]=1 on the same edge that grants i, pending[i] SHALL end set (the new event is kept).
REQ-015 FSM states SHALL be IDLE, STRETCH and GAP.
REQ-016 In IDLE with pending nonzero, the arbiter SHALL pick the winner combinationally by round-robin, starting from last_grant+1 and wrapping at NREQ-1 to 0.
REQ-017 On the next edge after REQ-016, the FSM SHALL enter STRETCH, latch the winner into grant_id and last_grant, and clear that pending bit.
REQ-018 stretch_out SHALL equal (state==STRETCH), decoded from registers only, with no combinational path from req.
REQ-019 STRETCH SHALL last exactly WIDTH cycles, then move to GAP for GAP cycles, then to IDLE. With GAP=0, STRETCH SHALL go directly to IDLE.
REQ-020 Latency: req[i] high in cycle t with the FSM idle SHALL give stretch_out high in cycles t+2 through t+1+WIDTH.
REQ-021 Back-to-back grants SHALL have a minimum rising-edge spacing of WIDTH+GAP+1 cycles, because IDLE lasts at least one cycle.
REQ-022 grant_id SHALL hold its value outside STRETCH.
REQ-023 Any req arriving during STRETCH or GAP SHALL only set pending and SHALL NOT alter the current pulse.
REQ-024 Drop event: req[i]=1 while pending[i]=1 and i is not granted on that edge. Events SHALL coalesce into one pending bit.
REQ-025 The stretch cycle counter SHALL be sized to hold max(WIDTH, GAP) and reset to 0 on every state entry.

Reset
REQ-026 While reset=1, the FSM SHALL go to IDLE and the cycle counter, pending, stretch_out, busy, grant_id and drop_cnt SHALL all be 0.
REQ-027 Reset SHALL set last_grant to NREQ-1 so that requester 0 has first priority.
REQ-028 Reset asserted mid-STRETCH SHALL drive stretch_out low the cycle after the reset edge and discard all pending events.

Configuration
REQ-029 Macro PULSE_ARB_DROP_CNT_EN.
- Defined: drop_cnt SHALL increment by 1 on each edge where at least one drop event occurs, and SHALL saturate at all ones.
- Undefined: the drop_cnt port SHALL remain and be tied to 0, and no counter logic SHALL be present.

Verification (NREQ=4, WIDTH=6, GAP=2, macro defined)
REQ-030 Reset, then req=4'b0100 in cycle 10 -> pending[2]=1 in cycle 11; stretch_out=1 and grant_id=2 in cycles 12-17; busy=1 in cycles 12-19; busy=0 in cycle 20.
REQ-031 req=4'b1111 in cycle 10 after reset -> grants in order 0,1,2,3 with stretch_out rising in cycles 12, 21, 30, 39.
REQ-032 last_grant=1 with pending=4'b1001 -> requester 3 is granted before requester 0.
REQ-033 req[1] pulsed in cycles 5 and 7 while pending[1]=1 -> one stretched pulse for requester 1 and drop_cnt=1.
REQ-034 req[0] high on the edge granting 0 -> pending[0] stays 1, and a second pulse for 0 follows after WIDTH+GAP+1 cycles.
REQ-035 reset pulsed in cycle 3 of STRETCH -> stretch_out=0, pending=0 and drop_cnt=0 the next cycle, and the FSM is in IDLE.
